// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle control sequencer for an RV32I subset datapath (R-type, I-type
// ALU, loads, stores, branches). Each instruction walks FETCH -> DECODE ->
// EXEC -> (MEM) -> (WB). The unit drives every datapath strobe and handshakes
// with a shared instruction/data memory port.
//
// Parameters
//   MEM_TIMEOUT : consecutive mem_req cycles without mem_ready before a
//                 memory-timeout trap; 0 disables the timeout.
//   CNT_W       : width of the retired-instruction counter.
//
// Optional feature macro: RETIRE_CNT_EN
//   defined   -> retired counts retiring instructions (wraps mod 2^CNT_W)
//   undefined -> retired is tied to 0 and no counter flops exist
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   opcode[6:0]           instruction opcode, sampled in DECODE
//   zero                  ALU zero flag, used in EXEC of a branch
//   mem_ready             memory completes the current access
//   mem_req, mem_we, iord memory request / write strobe / address select
//   ir_write, pc_write    IR load / PC update
//   pc_src                0 = PC+4, 1 = branch target (ALUOut)
//   reg_write, mem_to_reg register-file write / writeback select
//   alu_src_a, alu_src_b  ALU operand selects
//   alu_op                00 add, 01 branch compare, 10 R funct, 11 I funct
//   state[2:0]            current state encoding
//   trap_cause[1:0]       00 none, 01 illegal opcode, 10 memory timeout
//   retired[CNT_W-1:0]    retired-instruction count
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       state,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CL_R  = 3'd0,
        CL_I  = 3'd1,
        CL_LD = 3'd2,
        CL_ST = 3'd3,
        CL_BR = 3'd4
    } iclass_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    // The counter only has to hold 0 .. MEM_TIMEOUT-1; reaching the last
    // value with ready still low is the trap condition.
    localparam int              TMO_W       = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam int              TMO_LIMIT_I = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;
    localparam logic [TMO_W-1:0] TMO_LIMIT  = TMO_W'(TMO_LIMIT_I);
    localparam bit              TMO_EN      = (MEM_TIMEOUT > 0);

    state_t           state_r, state_nxt_s;
    iclass_t          class_r, class_nxt_s;
    logic [1:0]       cause_r, cause_nxt_s;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             tmo_hit_s;

    logic       mem_req_s, mem_we_s, iord_s, ir_write_s, pc_write_s, pc_src_s;
    logic       reg_write_s, mem_to_reg_s, alu_src_a_s;
    logic [1:0] alu_src_b_s, alu_op_s;

    // This request cycle is the last one allowed; mem_ready in it still wins.
    assign tmo_hit_s = TMO_EN && !mem_ready && (tmo_cnt_r == TMO_LIMIT);

    // Next-state, class/cause capture and control-strobe decode.
    always_comb begin
        state_nxt_s  = state_r;
        class_nxt_s  = class_r;
        cause_nxt_s  = cause_r;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        iord_s       = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        pc_src_s     = 1'b0;
        reg_write_s  = 1'b0;
        mem_to_reg_s = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;
        case (state_r)
            ST_FETCH: begin
                mem_req_s   = 1'b1;
                alu_src_b_s = 2'b01;
                if (mem_ready) begin
                    ir_write_s  = 1'b1;
                    pc_write_s  = 1'b1;
                    state_nxt_s = ST_DECODE;
                end else if (tmo_hit_s) begin
                    cause_nxt_s = 2'b10;
                    state_nxt_s = ST_TRAP;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                // ALU computes the branch target into ALUOut meanwhile.
                alu_src_b_s = 2'b10;
                state_nxt_s = ST_EXEC;
                case (opcode)
                    OP_R:    class_nxt_s = CL_R;
                    OP_I:    class_nxt_s = CL_I;
                    OP_LD:   class_nxt_s = CL_LD;
                    OP_ST:   class_nxt_s = CL_ST;
                    OP_BR:   class_nxt_s = CL_BR;
                    default: begin
                        cause_nxt_s = 2'b01;
                        state_nxt_s = ST_TRAP;
                    end
                endcase
            end
            ST_EXEC: begin
                alu_src_a_s = 1'b1;
                case (class_r)
                    CL_R: begin
                        alu_src_b_s = 2'b00;
                        alu_op_s    = 2'b10;
                        state_nxt_s = ST_WB;
                    end
                    CL_I: begin
                        alu_src_b_s = 2'b10;
                        alu_op_s    = 2'b11;
                        state_nxt_s = ST_WB;
                    end
                    CL_LD, CL_ST: begin
                        alu_src_b_s = 2'b10;
                        alu_op_s    = 2'b00;
                        state_nxt_s = ST_MEM;
                    end
                    CL_BR: begin
                        alu_src_b_s = 2'b00;
                        alu_op_s    = 2'b01;
                        pc_write_s  = zero;
                        pc_src_s    = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end
                    default: begin
                        // Corrupted class latch: park safely.
                        cause_nxt_s = 2'b01;
                        state_nxt_s = ST_TRAP;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
                mem_we_s  = (class_r == CL_ST);
                if (mem_ready) begin
                    if (class_r == CL_LD) begin
                        state_nxt_s = ST_WB;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end else if (tmo_hit_s) begin
                    cause_nxt_s = 2'b10;
                    state_nxt_s = ST_TRAP;
                end else begin
                    state_nxt_s = ST_MEM;
                end
            end
            ST_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = (class_r == CL_LD);
                state_nxt_s  = ST_FETCH;
            end
            ST_TRAP: begin
                state_nxt_s = ST_TRAP;
            end
            default: begin
                // Unused encodings fall into the trap hold.
                state_nxt_s = ST_TRAP;
            end
        endcase
    end

    // State, latched class and sticky trap cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
            class_r <= CL_R;
            cause_r <= 2'b00;
        end else begin
            state_r <= state_nxt_s;
            class_r <= class_nxt_s;
            cause_r <= cause_nxt_s;
        end
    end

    // Consecutive stalled-request counter; any state change restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (TMO_EN && mem_req_s && !mem_ready && (state_nxt_s == state_r)) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end
    end

`ifdef RETIRE_CNT_EN
    logic             retire_s;
    logic [CNT_W-1:0] retired_r;

    assign retire_s = ((state_r == ST_EXEC) && (class_r == CL_BR))
                    || ((state_r == ST_MEM) && (class_r == CL_ST) && mem_ready)
                    || (state_r == ST_WB);

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            retired_r <= retired_r + CNT_W'(1);
        end else begin
            retired_r <= retired_r;
        end
    end

    assign retired = retired_r;
`else
    assign retired = {CNT_W{1'b0}};
`endif

    // While reset is held every strobe is forced low, even mid-access.
    assign mem_req    = mem_req_s    & rst_n;
    assign mem_we     = mem_we_s     & rst_n;
    assign iord       = iord_s       & rst_n;
    assign ir_write   = ir_write_s   & rst_n;
    assign pc_write   = pc_write_s   & rst_n;
    assign pc_src     = pc_src_s     & rst_n;
    assign reg_write  = reg_write_s  & rst_n;
    assign mem_to_reg = mem_to_reg_s & rst_n;
    assign alu_src_a  = alu_src_a_s  & rst_n;
    assign alu_src_b  = alu_src_b_s  & {2{rst_n}};
    assign alu_op     = alu_op_s     & {2{rst_n}};
    assign state      = state_r;
    assign trap_cause = cause_r;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I subset datapath: R-type, I-type ALU, loads, stores and branches. It walks each instruction through FETCH/DECODE/EXEC/MEM/WB, drives every datapath control strobe, and handshakes with a shared instruction/data memory port. It sits beside the register file, ALU and ALU control. It replaces per-instruction static decode with a state-sequenced control unit.

Parameters:
MEM_TIMEOUT, 15, consecutive mem_req cycles without mem_ready before trapping; 0 disables the timeout.
CNT_W, 32, width of the retired-instruction counter (optional feature only).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous active-low
opcode  in  7  instruction register [6:0], sampled in DECODE
zero  in  1  ALU zero flag, sampled in EXEC of a branch
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe, qualified by mem_req
iord  out  1  address select: 0=PC, 1=ALUOut
ir_write  out  1  load instruction register
pc_write  out  1  update PC
pc_src  out  1  PC source: 0=ALU result (PC+4), 1=ALUOut (branch target)
reg_write  out  1  register file write
mem_to_reg  out  1  writeback select: 0=ALUOut, 1=memory data register
alu_src_a  out  1  0=old PC, 1=rs1
alu_src_b  out  2  00=rs2, 01=const 4, 10=immediate, 11=unused
alu_op  out  2  00=add, 01=branch compare, 10=R funct, 11=I funct
state  out  3  current state encoding
trap_cause  out  2  00=none, 01=illegal opcode, 10=memory timeout
retired  out  CNT_W  retired-instruction count

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Reset state is FETCH with trap_cause=00.
- While rst_n is low, all control outputs are forced to 0 combinationally. Reset is asynchronous, including mid-access; no pending access is preserved.
- Outputs are decoded from the current state plus latched class; mem_ready and zero gate only the strobes noted below. Every unlisted output is 0 in each state.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut). Latch class from opcode: R=0110011, I=0010011, LD=0000011, ST=0100011, BR=1100011.
  - Valid class: go to EXEC.
  - Any other opcode: trap_cause=01, go to TRAP.
- EXEC, by class:
  - R: alu_src_a=1, alu_src_b=00, alu_op=10, then go to WB.
  - I: alu_src_a=1, alu_src_b=10, alu_op=11, then go to WB.
  - LD/ST: alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEM.
  - BR: alu_src_a=1, alu_src_b=00, alu_op=01; pc_write=zero, pc_src=1. Go to FETCH; the instruction retires.
- MEM: mem_req=1, iord=1, mem_we=(class==ST). Stay until mem_ready=1.
  - LD: then go to WB.
  - ST: then go to FETCH; the instruction retires.
- WB: reg_write=1, mem_to_reg=(class==LD), then go to FETCH; the instruction retires.
- Timeout counter:
  - Counts consecutive cycles with mem_req=1 and mem_ready=0.
  - Clears on mem_ready=1 or on any state change.
  - When the count reaches MEM_TIMEOUT with ready still low: trap_cause=10, go to TRAP.
  - mem_ready arriving in the same cycle as the limit wins: no trap.
- TRAP: all strobes 0. Hold until rst_n is asserted. Inputs are ignored. trap_cause is sticky.
- Latency (mem_ready=1 immediately): R/I=4 cycles, BR=3, ST=4, LD=5.

Optional Feature:
RETIRE_CNT_EN.
- Defined: retired is a CNT_W-bit counter. It resets to 0, increments by 1 on each retire transition, wraps modulo 2^CNT_W, and does not count in TRAP.
- Undefined: retired is tied to 0 and no counter flops are instantiated.

Test Plan:
- Reset, mem_ready=1, opcode=0110011 → state sequence 0,1,2,4,0; reg_write=1 only in WB; alu_op=10 in EXEC; retired=1 (RETIRE_CNT_EN).
- opcode=0000011, mem_ready low for 3 MEM cycles then high → MEM held 4 cycles with mem_req=1, iord=1, mem_we=0; WB with mem_to_reg=1; total 8 cycles.
- opcode=1100011 with zero=1, then repeated with zero=0 → EXEC pc_write=1, pc_src=1 in the first case; pc_write=0 in the second; both return to FETCH after 3 cycles.
- opcode=0110111 → TRAP at cycle 2, trap_cause=01; 20 further cycles of activity change nothing; rst_n pulse returns state to FETCH and trap_cause to 00.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH → TRAP after exactly 4 request cycles, trap_cause=10; repeat with ready on cycle 4 → no trap.
- rst_n asserted asynchronously mid-MEM of a store → mem_req and mem_we drop to 0 before the next clock edge; after release, state=FETCH and retired unchanged by the aborted store.
